// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encodings used by the decoder and the
// execute unit, plus the execute unit's FSM state type.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_NOR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exec_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier datapath: one multiplier bit per step,
// fixed WIDTH steps, low WIDTH bits of the product kept.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_next,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;

    // acc_next already includes the current step so the final product is
    // available combinationally on the last iteration edge.
    assign acc_next = multiplier[0] ? (acc + multiplicand) : acc;
    assign last     = (count == LAST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multiplicand <= '0;
            multiplier   <= '0;
            acc          <= '0;
            count        <= '0;
        end else if (load) begin
            multiplicand <= a;
            multiplier   <= b;
            acc          <= '0;
            count        <= '0;
        end else if (step) begin
            acc          <= acc_next;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            count        <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute unit: single-cycle ADD/SUB/SLT/logic ops and a
// WIDTH-cycle iterative MUL, with registered Result/Zero and a Done pulse.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    exec_state_t      state;
    exec_state_t      state_next;
    logic [WIDTH-1:0] op_result;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             zero_q;
    logic             zero_d;
    logic             done_q;
    logic             done_d;
    logic             mul_load;
    logic             mul_step;
    logic             mul_last;

    always_comb begin
        op_result = '0;
        case (ALUControl)
            ALU_AND: op_result = SrcA & SrcB;
            ALU_OR:  op_result = SrcA | SrcB;
            ALU_ADD: op_result = SrcA + SrcB;
            ALU_XOR: op_result = SrcA ^ SrcB;
            ALU_SUB: op_result = SrcA - SrcB;
            ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_NOR: op_result = ~(SrcA | SrcB);
            default: op_result = '0;
        endcase
    end

    mul_shift_add #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mul_load),
        .step     (mul_step),
        .a        (SrcA),
        .b        (SrcB),
        .acc_next (acc_next),
        .last     (mul_last)
    );

    // Start is only looked at in IDLE, so requests during a MUL are dropped.
    always_comb begin
        state_next = state;
        result_d   = result_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (ALUControl == ALU_MUL) begin
                        mul_load   = 1'b1;
                        state_next = MUL;
                    end else begin
                        result_d = op_result;
                        zero_d   = (op_result == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d   = acc_next;
                    zero_d     = (acc_next == '0);
                    done_d     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign Result = result_q;
    assign Zero   = zero_q;
    assign Done   = done_q;
    assign Busy   = (state == MUL);

endmodule
